prog_loader: RTL

- Boot-time program loader that sits directly upstream of the multi-cycle MIPS core and its unified instruction/data memory.
- Receives a framed program image as a byte stream (valid/ready) and assembles little-endian 32-bit words.
- Writes each word into memory through a single write port, verifies a trailing XOR checksum, and holds the core in reset until the image is accepted.

---
 rtl/prog_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader
//   Boot-time program loader for the multi-cycle MIPS core.
//   It takes a framed little-endian byte stream of the form
//   [N][word 0 .. word N-1][xor checksum] and assembles each field into a
//   32-bit word. Every data word goes out through a single memory write port.
//   The core is held in reset until the whole image has been accepted and its
//   checksum matches.
//
// Ports
//   CLK       system clock, all logic on the rising edge
//   RST       synchronous active-high reset
//   rx_data   incoming byte
//   rx_valid  rx_data valid this cycle
//   rx_ready  loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
//   mem_addr  memory word address for the write
//   mem_wd    memory write data (last assembled program word)
//   mem_we    memory write strobe, one cycle per word
//   cpu_rstn  active-low core reset, released only once the load succeeds
//   done      image loaded and checksum matched (sticky)
//   err       frame rejected (sticky)
//   word_cnt  number of words written so far
module prog_loader #(
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned AW        = 32,
  localparam int unsigned CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  output logic          mem_we,
  output logic          cpu_rstn,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] word_cnt
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;          // byte position inside the current field
  logic [23:0]   sr_q, sr_d;            // first three bytes of the current field
  logic [31:0]   n_q, n_d;              // full 32-bit header word count
  logic [31:0]   acc_q, acc_d;          // running xor of the data words
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wd_q, mem_wd_d;
  logic          mem_we_q, mem_we_d;
  logic          rx_ready_q, rx_ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cpu_rstn_q, cpu_rstn_d;

  logic          accept;
  logic          last_byte;
  logic [31:0]   word;

  // A transfer only happens when the registered ready is high, so the
  // assembler is naturally frozen in WRITE, DONE and ERR.
  assign accept    = rx_valid & rx_ready_q;
  assign last_byte = accept && (idx_q == 2'd3);
  // Bytes arrive least significant first, so the fourth byte is the MSB.
  assign word      = {rx_data, sr_q};

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    sr_d       = sr_q;
    n_d        = n_q;
    acc_d      = acc_q;
    word_cnt_d = word_cnt_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_we_d   = 1'b0;

    if (accept) begin
      idx_d = idx_q + 2'd1;
      sr_d  = {rx_data, sr_q[23:8]};
    end

    unique case (state_q)
      S_HDR: begin
        if (last_byte) begin
          n_d = word;
          // Range check on all 32 bits: a large count with zero low bits
          // must still be rejected.
          if (word == 32'd0 || word > 32'(MAX_WORDS)) state_d = S_ERR;
          else                                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte) begin
          state_d    = S_WRITE;
          mem_we_d   = 1'b1;
          mem_wd_d   = word;
          mem_addr_d = AW'(BASE_ADDR) + AW'(word_cnt_q);
          acc_d      = acc_q ^ word;
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + CW'(1);
        if (32'(word_cnt_d) == n_q) state_d = S_CSUM;
        else                        state_d = S_DATA;
      end
      S_CSUM: begin
        if (last_byte) begin
          if (word == acc_q) state_d = S_DONE;
          else               state_d = S_ERR;
        end
      end
      S_DONE: ;
      S_ERR:  ;
      default: state_d = S_ERR;
    endcase

    // Outputs are registered, decoded from the state being entered.
    rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_rstn_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (RST) begin
      state_q    <= S_HDR;
      idx_q      <= 2'd0;
      sr_q       <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      word_cnt_q <= '0;
      mem_addr_q <= AW'(BASE_ADDR);
      mem_wd_q   <= '0;
      mem_we_q   <= 1'b0;
      rx_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rstn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sr_q       <= sr_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      word_cnt_q <= word_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_we_q   <= mem_we_d;
      rx_ready_q <= rx_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rstn_q <= cpu_rstn_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign mem_we   = mem_we_q;
  assign cpu_rstn = cpu_rstn_q;
  assign done     = done_q;
  assign err      = err_q;
  assign word_cnt = word_cnt_q;

endmodule
